// File: rtl/magnitude_search_ctrl_if.sv
// magnitude_search_ctrl_if: bundles the search controller's control handshake,
// its comparator probe (guess out, less/equal/greater in) and its result outputs.
// master = controller side, slave = environment (comparator + requester).
interface magnitude_search_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    logic             start;
    logic [WIDTH-1:0] Data_out_A;
    logic             less;
    logic             equal;
    logic             greater;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] found_value;
    logic [CNT_W-1:0] step_count;

    modport master (
        input  start, less, equal, greater,
        output Data_out_A, busy, done, error, found_value, step_count
    );

    modport slave (
        output start, less, equal, greater,
        input  Data_out_A, busy, done, error, found_value, step_count
    );
endinterface

// File: rtl/magnitude_search_ctrl.sv
// magnitude_search_ctrl: binary-search initiator for a magnitude comparator.
// Drives successive guesses on Data_out_A, reads less/equal/greater back and
// recovers the comparator's B operand, flagging inconsistent answers.
// Optional macro CMP_RESULT_REG_EN: comparator with registered flags; each
// probe then takes a SETTLE cycle (present guess) and a SAMPLE cycle.
module magnitude_search_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    magnitude_search_ctrl_if.master bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    // lo/hi carry one extra bit so lo > hi and underflow are observable
    localparam int unsigned LW    = WIDTH + 1;
    localparam logic [LW-1:0] HI_INIT = LW'((2 ** WIDTH) - 1);

`ifdef CMP_RESULT_REG_EN
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [LW-1:0]    lo_q, lo_d;
    logic [LW-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [LW-1:0]    new_lo;
    logic [LW-1:0]    new_hi;
    logic             flags_onehot;
    logic             less_bad;
    logic             greater_bad;

    function automatic logic [WIDTH-1:0] midpoint(input logic [LW-1:0] a,
                                                  input logic [LW-1:0] b);
        logic [LW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return WIDTH'(sum >> 1);
    endfunction

    // Candidate bounds after the current answer and their consistency checks
    assign new_lo       = LW'(guess_q) + LW'(1);
    assign new_hi       = LW'(guess_q) - LW'(1);
    assign flags_onehot = $onehot({bus.less, bus.equal, bus.greater});
    assign less_bad     = (new_lo > hi_q);
    assign greater_bad  = new_hi[WIDTH] || (new_hi < lo_q);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        found_d = found_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    lo_d    = '0;
                    hi_d    = HI_INIT;
                    guess_d = midpoint('0, HI_INIT);
                    step_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef CMP_RESULT_REG_EN
                    state_d = S_SETTLE;
`else
                    state_d = S_PROBE;
`endif
                end
            end
`ifdef CMP_RESULT_REG_EN
            S_SETTLE: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
`else
            S_PROBE: begin
`endif
                step_d = step_q + CNT_W'(1);
                if (!flags_onehot || (bus.less && less_bad) ||
                    (bus.greater && greater_bad)) begin
                    error_d = 1'b1;
                    found_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (bus.equal) begin
                    found_d = guess_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (bus.less) begin
                        lo_d    = new_lo;
                        guess_d = midpoint(new_lo, hi_q);
                    end else begin
                        hi_d    = new_hi;
                        guess_d = midpoint(lo_q, new_hi);
                    end
`ifdef CMP_RESULT_REG_EN
                    state_d = S_SETTLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any search immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            guess_q <= '0;
            found_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            found_q <= found_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.Data_out_A  = guess_q;
    assign bus.found_value = found_q;
    assign bus.step_count  = step_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

endmodule
